// File: rtl/display_timing_pkg.sv
// Shared timing constants, pixel type and sync helper for the display scanout path.
package display_timing_pkg;

  // RGB565 pixel as it sits in the framebuffer and on the panel bus
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // Default 320x240 framebuffer shown as 640x480@60 with 2x doubling
  localparam int DEF_FB_WIDTH        = 320;
  localparam int DEF_FB_HEIGHT       = 240;
  localparam int DEF_SCALE_SHIFT     = 1;
  localparam int DEF_H_FP            = 16;
  localparam int DEF_H_SYNC          = 96;
  localparam int DEF_H_BP            = 48;
  localparam int DEF_V_FP            = 10;
  localparam int DEF_V_SYNC          = 2;
  localparam int DEF_V_BP            = 33;
  localparam bit DEF_SYNC_ACTIVE_LOW = 1'b1;

  // Derived display geometry
  localparam int DEF_H_ACTIVE = DEF_FB_WIDTH << DEF_SCALE_SHIFT;
  localparam int DEF_V_ACTIVE = DEF_FB_HEIGHT << DEF_SCALE_SHIFT;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_H_CNT_W  = $clog2(DEF_H_TOTAL);
  localparam int DEF_V_CNT_W  = $clog2(DEF_V_TOTAL);

  // Pin level for a sync signal given its logical assertion and polarity
  function automatic logic sync_level(input logic asserted, input logic active_low);
    return asserted ^ active_low;
  endfunction

endpackage

// File: rtl/display_axis_counter.sv
// One timing axis (horizontal or vertical): position counter with wrap tick and
// active/sync region decode. Regions are compared on the full counter width.
module display_axis_counter #(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int TOTAL  = ACTIVE + FP + SYNC + BP,
  parameter int W      = $clog2(TOTAL)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         step,
  output logic [W-1:0] count,
  output logic         tick,
  output logic         active,
  output logic         sync
);

  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] ACTIVE_END = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_END   = W'(ACTIVE + FP + SYNC);

  logic [W-1:0] count_reg;
  logic         at_last;

  assign at_last = (count_reg == LAST);
  // Tick marks the edge on which this axis wraps back to zero
  assign tick    = step && !clear && at_last;

  // Position counter: clear wins over step so a stopped scan parks at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (step) begin
      count_reg <= at_last ? '0 : count_reg + W'(1);
    end
  end

  assign count  = count_reg;
  assign active = (count_reg < ACTIVE_END);
  assign sync   = (count_reg >= SYNC_START) && (count_reg < SYNC_END);

endmodule

// File: rtl/display_scanout.sv
// Display-side framebuffer reader: generates VGA timing, issues pixel-doubled
// framebuffer read coordinates and realigns the 1-cycle RAM read data with
// sync/DE so every output leaves two clocks after its counter position.
module display_scanout
  import display_timing_pkg::*;
#(
  parameter int FB_WIDTH        = DEF_FB_WIDTH,
  parameter int FB_HEIGHT       = DEF_FB_HEIGHT,
  parameter int SCALE_SHIFT     = DEF_SCALE_SHIFT,
  parameter int H_FP            = DEF_H_FP,
  parameter int H_SYNC          = DEF_H_SYNC,
  parameter int H_BP            = DEF_H_BP,
  parameter int V_FP            = DEF_V_FP,
  parameter int V_SYNC          = DEF_V_SYNC,
  parameter int V_BP            = DEF_V_BP,
  parameter bit SYNC_ACTIVE_LOW = DEF_SYNC_ACTIVE_LOW
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  output logic [$clog2(FB_WIDTH)-1:0]  x_out,
  output logic [$clog2(FB_HEIGHT)-1:0] y_out,
  input  logic [15:0]                  pixel_in,
  output logic                         hsync,
  output logic                         vsync,
  output logic                         de,
  output logic [15:0]                  rgb,
  output logic                         frame_start
);

  localparam int H_ACTIVE = FB_WIDTH << SCALE_SHIFT;
  localparam int V_ACTIVE = FB_HEIGHT << SCALE_SHIFT;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W      = $clog2(H_TOTAL);
  localparam int V_W      = $clog2(V_TOTAL);
  localparam int X_W      = $clog2(FB_WIDTH);
  localparam int Y_W      = $clog2(FB_HEIGHT);

  // Idle (deasserted) pin level of hsync/vsync
  localparam logic SYNC_IDLE = sync_level(1'b0, SYNC_ACTIVE_LOW);

  // ---------------- counters ----------------
  logic           scan_off;
  logic [H_W-1:0] h_count;
  logic [V_W-1:0] v_count;
  logic           h_tick;
  logic           v_tick;
  logic           h_active;
  logic           v_active;
  logic           h_sync;
  logic           v_sync;

  assign scan_off = !en;

  display_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .TOTAL  (H_TOTAL),
    .W      (H_W)
  ) u_h_axis (
    .clk    (clk),
    .rst    (rst),
    .clear  (scan_off),
    .step   (en),
    .count  (h_count),
    .tick   (h_tick),
    .active (h_active),
    .sync   (h_sync)
  );

  // The vertical axis advances only on the horizontal wrap edge
  display_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .TOTAL  (V_TOTAL),
    .W      (V_W)
  ) u_v_axis (
    .clk    (clk),
    .rst    (rst),
    .clear  (scan_off),
    .step   (h_tick),
    .count  (v_count),
    .tick   (v_tick),
    .active (v_active),
    .sync   (v_sync)
  );

  // ---------------- stage 0: read address ----------------
  logic pix_active;

  assign pix_active = h_active && v_active;
  // Inside the active window h>>S < FB_WIDTH and v>>S < FB_HEIGHT, so the
  // truncating casts never drop significant bits
  assign x_out = pix_active ? X_W'(h_count >> SCALE_SHIFT) : '0;
  assign y_out = pix_active ? Y_W'(v_count >> SCALE_SHIFT) : '0;

  // Tracks that the counters currently sit at (0,0): after reset, while
  // stopped, and after the edge on which both axes wrap together
  logic at_origin_reg;

  // Origin flag follows the counter's next state without a wide compare
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      at_origin_reg <= 1'b1;
    end else begin
      at_origin_reg <= scan_off || v_tick;
    end
  end

  // ---------------- stage 1: wait for RAM data ----------------
  logic s1_active_reg;
  logic s1_hsync_reg;
  logic s1_vsync_reg;
  logic s1_first_reg;

  // Delay region flags one clock to meet the RAM read data; a stopped scan
  // loads inactive values so no stale pixel reaches the output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_active_reg <= 1'b0;
      s1_hsync_reg  <= 1'b0;
      s1_vsync_reg  <= 1'b0;
      s1_first_reg  <= 1'b0;
    end else begin
      s1_active_reg <= en && pix_active;
      s1_hsync_reg  <= en && h_sync;
      s1_vsync_reg  <= en && v_sync;
      s1_first_reg  <= en && at_origin_reg;
    end
  end

  // ---------------- stage 2: output registers ----------------
  logic    de_reg;
  logic    hsync_reg;
  logic    vsync_reg;
  logic    frame_start_reg;
  rgb565_t rgb_reg;

  // Register all panel outputs together; pixel data is blanked outside DE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_reg          <= 1'b0;
      hsync_reg       <= SYNC_IDLE;
      vsync_reg       <= SYNC_IDLE;
      frame_start_reg <= 1'b0;
      rgb_reg         <= '0;
    end else begin
      de_reg          <= s1_active_reg;
      hsync_reg       <= sync_level(s1_hsync_reg, SYNC_ACTIVE_LOW);
      vsync_reg       <= sync_level(s1_vsync_reg, SYNC_ACTIVE_LOW);
      frame_start_reg <= s1_first_reg;
      rgb_reg         <= s1_active_reg ? rgb565_t'(pixel_in) : '0;
    end
  end

  assign de          = de_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign frame_start = frame_start_reg;
  assign rgb         = rgb_reg;

endmodule

// File: tb/tb_display_scanout.sv
// Directed bench for display_scanout: full 640x480 instance for reset, line
// timing, doubling, en stop/restart and async reset; a tiny-geometry instance
// for whole-frame timing (vsync, frame period).
module tb_display_scanout;

  logic clk = 1'b0;
  logic rst;
  logic en;

  always #5 clk = ~clk;

  // full-size instance
  logic [8:0]  x_out;
  logic [7:0]  y_out;
  logic [15:0] pixel_in;
  logic        hsync, vsync, de, frame_start;
  logic [15:0] rgb;

  // small instance: 8x4 fb -> 16x8 active, H_TOTAL 24, V_TOTAL 12, frame 288
  logic [2:0]  xs;
  logic [1:0]  ys;
  logic [15:0] pixs;
  logic        hss, vss, des, fss;
  logic [15:0] rgbs;

  display_scanout u_dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .x_out       (x_out),
    .y_out       (y_out),
    .pixel_in    (pixel_in),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .rgb         (rgb),
    .frame_start (frame_start)
  );

  display_scanout #(
    .FB_WIDTH(8), .FB_HEIGHT(4), .SCALE_SHIFT(1),
    .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_ACTIVE_LOW(1'b1)
  ) u_small (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .x_out       (xs),
    .y_out       (ys),
    .pixel_in    (pixs),
    .hsync       (hss),
    .vsync       (vss),
    .de          (des),
    .rgb         (rgbs),
    .frame_start (fss)
  );

  // framebuffer content: fb[x + W*y] = x ^ (y << 8)
  function automatic logic [15:0] fb(input int x, input int y);
    int t;
    t = x ^ (y << 8);
    return t[15:0];
  endfunction

  // 1-cycle-latency RAM models
  always @(posedge clk) begin
    pixel_in <= fb(int'(x_out), int'(y_out));
    pixs     <= fb(int'(xs), int'(ys));
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  int          de_cnt [5];
  int          hs_low [5];
  int          hs_first [5];
  int          de_err, rgb_err, vs_low, fs_cnt;
  logic [15:0] cap_pix;
  logic [8:0]  cap_x3, cap_x638, cap_x639, cap_x640;
  logic [7:0]  cap_y3, cap_y4;
  int          s_de, s_hs, s_vs, s_vs_first, s_fs_n, s_err, m_fs;
  int          s_fs_pos [2];
  int          h, v, hs, vsv;
  logic        exp_de, exp_des;
  logic [15:0] exp_rgb;

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      de_cnt[i] = 0; hs_low[i] = 0; hs_first[i] = -1;
    end
    de_err = 0; rgb_err = 0; vs_low = 0; fs_cnt = 0;
    cap_pix = '0; cap_x3 = '0; cap_x638 = '0; cap_x639 = '0; cap_x640 = 9'h1ff;
    cap_y3 = '0; cap_y4 = '0;

    // ---- reset held with en=1 ----
    repeat (3) step();
    chk("rst_de", de, 0);
    chk("rst_rgb", rgb, 0);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_x_out", x_out, 0);
    chk("rst_y_out", y_out, 0);
    chk("rst_frame_start", frame_start, 0);

    // ---- release: frame_start at clock 2 ----
    rst = 1'b0;
    step();
    chk("start_c1_fs", frame_start, 0);
    chk("start_c1_de", de, 0);
    step();
    chk("start_c2_fs", frame_start, 1);
    chk("start_c2_de", de, 1);

    // ---- first five lines: outputs now show counter position p ----
    for (int p = 0; p < 4000; p++) begin
      h = p % 800;
      v = p / 800;
      exp_de  = (h < 640);
      exp_rgb = exp_de ? fb(h >> 1, v >> 1) : 16'h0000;
      if (de) de_cnt[v]++;
      if (de !== exp_de) de_err++;
      if (!hsync) begin
        hs_low[v]++;
        if (hs_first[v] < 0) hs_first[v] = h;
      end
      if (!vsync) vs_low++;
      if (frame_start) fs_cnt++;
      if (rgb !== exp_rgb) rgb_err++;
      if (p == 3210) cap_pix = rgb;
      // x_out/y_out reflect the counters, two positions ahead of the outputs
      if (p + 2 == 3)    cap_x3   = x_out;
      if (p + 2 == 638)  cap_x638 = x_out;
      if (p + 2 == 639)  cap_x639 = x_out;
      if (p + 2 == 640)  cap_x640 = x_out;
      if (p + 2 == 2405) cap_y3   = y_out;
      if (p + 2 == 3205) cap_y4   = y_out;
      step();
    end
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("line%0d_de_count", i), de_cnt[i], 640);
      chk($sformatf("line%0d_hsync_low", i), hs_low[i], 96);
      chk($sformatf("line%0d_hsync_start", i), hs_first[i], 656);
    end
    chk("lines_de_align_err", de_err, 0);
    chk("lines_rgb_err", rgb_err, 0);
    chk("lines_vsync_low", vs_low, 0);
    chk("lines_frame_start_cnt", fs_cnt, 1);
    chk("pix_h10_v4", cap_pix, 16'h0205);
    chk("x_out_h3", cap_x3, 1);
    chk("x_out_h638", cap_x638, 319);
    chk("x_out_h639", cap_x639, 319);
    chk("x_out_h640", cap_x640, 0);
    chk("y_out_v3", cap_y3, 1);
    chk("y_out_v4", cap_y4, 2);

    // ---- en dropped with counters at h=300 (line 5) ----
    repeat (298) step();
    chk("pre_drop_de", de, 1);
    chk("pre_drop_rgb", rgb, 16'h0295);
    en = 1'b0;
    step();
    chk("drop_c1_x_out", x_out, 0);
    chk("drop_c1_y_out", y_out, 0);
    step();
    chk("drop_c2_de", de, 0);
    chk("drop_c2_rgb", rgb, 0);
    repeat (4) step();
    chk("idle_de", de, 0);
    chk("idle_fs", frame_start, 0);
    chk("idle_hsync", hsync, 1);
    en = 1'b1;
    step();
    chk("restart_c1_fs", frame_start, 0);
    step();
    chk("restart_c2_fs", frame_start, 1);
    chk("restart_c2_de", de, 1);
    step();
    step();
    chk("restart_p2_rgb", rgb, 1);
    chk("restart_p2_x_out", x_out, 2);

    // ---- async reset pulse mid-line ----
    repeat (398) step();
    chk("pre_rst_de", de, 1);
    chk("pre_rst_rgb", rgb, 200);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_de", de, 0);
    chk("async_rst_rgb", rgb, 0);
    chk("async_rst_fs", frame_start, 0);
    chk("async_rst_hsync", hsync, 1);
    chk("async_rst_x_out", x_out, 0);
    @(negedge clk);
    step();
    rst = 1'b0;
    step();
    chk("recover_c1_fs", frame_start, 0);
    step();
    chk("recover_c2_fs", frame_start, 1);
    chk("recover_c2_de", de, 1);

    // ---- whole-frame timing on the small instance ----
    s_de = 0; s_hs = 0; s_vs = 0; s_vs_first = -1; s_fs_n = 0; s_err = 0; m_fs = 0;
    s_fs_pos[0] = -1; s_fs_pos[1] = -1;
    for (int k = 0; k < 600; k++) begin
      hs  = k % 24;
      vsv = (k / 24) % 12;
      exp_des = (hs < 16) && (vsv < 8);
      if (k < 288) begin
        if (des) s_de++;
        if (!hss) s_hs++;
        if (!vss) begin
          s_vs++;
          if (s_vs_first < 0) s_vs_first = k;
        end
      end
      if (fss) begin
        if (s_fs_n < 2) s_fs_pos[s_fs_n] = k;
        s_fs_n++;
      end
      if (des !== exp_des) s_err++;
      if (rgbs !== (exp_des ? fb(hs >> 1, vsv >> 1) : 16'h0000)) s_err++;
      if (frame_start) m_fs++;
      step();
    end
    chk("small_de_per_frame", s_de, 128);
    chk("small_hsync_low_per_frame", s_hs, 36);
    chk("small_vsync_low", s_vs, 48);
    chk("small_vsync_start", s_vs_first, 216);
    chk("small_fs_first", s_fs_pos[0], 0);
    chk("small_fs_second", s_fs_pos[1], 288);
    chk("small_fs_count", s_fs_n, 3);
    chk("small_pixel_err", s_err, 0);
    chk("main_fs_single", m_fs, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
